// File: rtl/simple_calci.sv
// Registered 2-bit calculator: add, |subtract|, multiply, restoring divide.
// One-cycle latency from a qualified input to out_valid.
module simple_calci (
    input  logic clk,
    input  logic rst_n,
    input  logic in_valid,
    input  logic a1,
    input  logic a0,
    input  logic b1,
    input  logic b0,
    input  logic s1,
    input  logic s0,
    output logic y3,
    output logic y2,
    output logic y1,
    output logic y0,
    output logic yrep,
    output logic out_valid
);

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    logic [1:0] a;
    logic [1:0] b;
    logic [1:0] op;
    logic [3:0] res;
    logic       res_flag;
    logic [3:0] y_q;

    logic [1:0] div_p1;
    logic [1:0] div_r1;
    logic [2:0] div_p2;
    logic [1:0] div_r2;
    logic [1:0] div_q;

    assign a  = {a1, a0};
    assign b  = {b1, b0};
    assign op = {s1, s0};

    // Restoring division, one quotient bit per unrolled step, MSB first.
    always_comb begin
        div_p1   = {1'b0, a[1]};
        div_q[1] = (div_p1 >= b);
        div_r1   = div_q[1] ? (div_p1 - b) : div_p1;
        div_p2   = {div_r1, a[0]};
        div_q[0] = (div_p2 >= {1'b0, b});
        div_r2   = div_q[0] ? 2'(div_p2 - {1'b0, b}) : div_p2[1:0];
    end

    always_comb begin
        res      = 4'b0000;
        res_flag = 1'b0;
        case (op)
            OP_ADD: res = {2'b00, a} + {2'b00, b};
            OP_SUB: begin
                res_flag = (a < b);
                res      = (a >= b) ? {2'b00, a - b} : {2'b00, b - a};
            end
            OP_MUL: res = {2'b00, a} * {2'b00, b};
            OP_DIV: begin
                if (b == 2'b00) begin
                    res_flag = 1'b1;
                end else begin
                    res = {div_q, div_r2};
                end
            end
            default: res = 4'b0000;
        endcase
    end

    // Result registers only load on a qualified input, so idle operands never reach the outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q       <= 4'b0000;
            yrep      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                y_q  <= res;
                yrep <= res_flag;
            end
        end
    end

    assign y3 = y_q[3];
    assign y2 = y_q[2];
    assign y1 = y_q[1];
    assign y0 = y_q[0];

endmodule

// File: tb/tb_simple_calci.sv
// Scoreboard bench for simple_calci: stimulus pushes model results tagged with
// their due cycle; an independent monitor pops and compares on every cycle.
module tb_simple_calci;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic in_valid = 1'b0;
    logic a1 = 1'b0, a0 = 1'b0, b1 = 1'b0, b0 = 1'b0, s1 = 1'b0, s0 = 1'b0;
    logic y3, y2, y1, y0, yrep, out_valid;

    typedef struct {
        int         due;
        logic [3:0] y;
        logic       f;
    } exp_t;

    exp_t       sb[$];
    int         cyc = 0;
    int         vectors = 0;
    int         miscompares = 0;
    logic [3:0] last_y = 4'b0000;
    logic       last_f = 1'b0;

    simple_calci dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .a1(a1), .a0(a0), .b1(b1), .b0(b0), .s1(s1), .s0(s0),
        .y3(y3), .y2(y2), .y1(y1), .y0(y0), .yrep(yrep), .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    // Reference behaviour straight from the arithmetic definitions.
    task automatic model(input int a, input int b, input int op,
                         output logic [3:0] y, output logic f);
        int r;
        r = 0;
        f = 1'b0;
        case (op)
            0: r = a + b;
            1: begin
                r = (a >= b) ? a - b : b - a;
                f = (a < b);
            end
            2: r = a * b;
            default: begin
                if (b == 0) begin
                    r = 0;
                    f = 1'b1;
                end else begin
                    r = (a / b) * 4 + (a % b);
                end
            end
        endcase
        y = 4'(r);
    endtask

    task automatic check(input string name, input logic [5:0] got, input logic [5:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got {out_valid,yrep,y}=%b want %b", name, got, want);
        end
    endtask

    task automatic issue(input int a, input int b, input int op);
        logic [3:0] ey;
        logic       ef;
        logic [1:0] av, bv, ov;
        @(negedge clk);
        av = 2'(a);
        bv = 2'(b);
        ov = 2'(op);
        {a1, a0} = av;
        {b1, b0} = bv;
        {s1, s0} = ov;
        in_valid = 1'b1;
        model(a, b, op, ey, ef);
        sb.push_back('{cyc + 1, ey, ef});
        last_y = ey;
        last_f = ef;
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
        {a1, a0, b1, b0, s1, s0} = 6'($urandom);
    endtask

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (sb.size() > 0 && sb[0].due == cyc) begin
                e = sb.pop_front();
                vectors++;
                if (out_valid !== 1'b1 || {y3, y2, y1, y0} !== e.y || yrep !== e.f) begin
                    miscompares++;
                    $display("FAIL result cyc %0d: got valid=%b y=%b yrep=%b want valid=1 y=%b yrep=%b",
                             cyc, out_valid, {y3, y2, y1, y0}, yrep, e.y, e.f);
                end
            end else if (out_valid !== 1'b0) begin
                vectors++;
                miscompares++;
                $display("FAIL spurious_valid cyc %0d: got out_valid=%b want 0", cyc, out_valid);
            end
        end
    end

    // Stimulus
    initial begin
        #2 rst_n = 1'b0;
        #1 check("async_reset", {out_valid, yrep, y3, y2, y1, y0}, 6'b0);
        @(negedge clk);
        in_valid = 1'b1;
        {a1, a0, b1, b0, s1, s0} = 6'b111110;
        repeat (2) begin
            @(posedge clk);
            #1 check("reset_held", {out_valid, yrep, y3, y2, y1, y0}, 6'b0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b1;

        issue(2, 1, 0); issue(3, 3, 0);
        issue(2, 1, 1); issue(0, 3, 1);
        issue(3, 3, 2); issue(2, 0, 2);
        issue(1, 3, 3); issue(2, 2, 3); issue(2, 0, 3);

        @(negedge clk);
        in_valid = 1'b0;
        a1 = 1'bx;
        a0 = 1'bx;
        repeat (2) begin
            @(posedge clk);
            #1 check("hold_x", {out_valid, yrep, y3, y2, y1, y0}, {1'b0, last_f, last_y});
        end

        for (int op = 0; op < 4; op++)
            for (int a = 0; a < 4; a++)
                for (int b = 0; b < 4; b++)
                    issue(a, b, op);

        repeat (400) begin
            if ($urandom_range(0, 2) == 0) idle();
            else issue(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end

        repeat (3) idle();
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d results outstanding want 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
